// File: rtl/cpu_datapath_if.sv
// Controller-strobe, memory-port and feedback bundle for the accumulator datapath.
interface cpu_datapath_if #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CNT_W  = 16
);
    logic              sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e;
    logic [DWIDTH-1:0] mem_rdata;
    logic [AWIDTH-1:0] mem_addr;
    logic              mem_re, mem_we, mem_wdata_oe;
    logic [DWIDTH-1:0] mem_wdata;
    logic [2:0]        opcode;
    logic              is_zero;
    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] acc;
    logic              halted;
    logic [CNT_W-1:0]  instr_count;

    // master: controller + memory side; slave: the datapath
    modport master (
        output sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, mem_rdata,
        input  mem_addr, mem_re, mem_we, mem_wdata, mem_wdata_oe,
               opcode, is_zero, pc, acc, halted, instr_count
    );
    modport slave (
        input  sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e, mem_rdata,
        output mem_addr, mem_re, mem_we, mem_wdata, mem_wdata_oe,
               opcode, is_zero, pc, acc, halted, instr_count
    );
endinterface

// File: rtl/cpu_datapath.sv
// Accumulator datapath: PC, IR, ACC, ALU, memory address mux, halt flag and
// saturating retired-instruction counter. DWIDTH must equal AWIDTH+3.
module cpu_datapath #(
    parameter int AWIDTH = 5,
    parameter int DWIDTH = 8,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    cpu_datapath_if.slave bus
);
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;

    logic [AWIDTH-1:0] pc;
    logic [DWIDTH-1:0] ir, acc, alu_out;
    logic [CNT_W-1:0]  instr_count;
    logic              halted, ld_ir_q, frozen;
    logic [2:0]        opcode;

    assign opcode = ir[DWIDTH-1:DWIDTH-3];
    // A halt strobe freezes state already at the edge that sets the flag.
    assign frozen = halted | bus.halt;

    always_comb begin
        alu_out = acc;
        case (opcode)
            OP_ADD:  alu_out = acc + bus.mem_rdata;
            OP_AND:  alu_out = acc & bus.mem_rdata;
            OP_XOR:  alu_out = acc ^ bus.mem_rdata;
            OP_LDA:  alu_out = bus.mem_rdata;
            default: alu_out = acc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            ir          <= '0;
            acc         <= '0;
            halted      <= 1'b0;
            ld_ir_q     <= 1'b0;
            instr_count <= '0;
        end else begin
            ld_ir_q <= bus.ld_ir;
            if (bus.halt) halted <= 1'b1;
            if (!frozen) begin
                if (bus.ld_ir) ir <= bus.mem_rdata;
                if (bus.ld_pc)       pc <= ir[AWIDTH-1:0];
                else if (bus.inc_pc) pc <= pc + 1'b1;
                if (bus.ld_ac) acc <= alu_out;
                // count fetches once even when ld_ir is held for several cycles
                if (bus.ld_ir && !ld_ir_q && instr_count != '1)
                    instr_count <= instr_count + 1'b1;
            end
        end
    end

    assign bus.mem_addr     = bus.sel ? pc : ir[AWIDTH-1:0];
    assign bus.mem_re       = bus.rd & ~halted;
    assign bus.mem_we       = bus.wr & ~halted;
    assign bus.mem_wdata    = acc;
    assign bus.mem_wdata_oe = bus.data_e & ~halted;
    assign bus.opcode       = opcode;
    assign bus.is_zero      = (acc == '0);
    assign bus.pc           = pc;
    assign bus.acc          = acc;
    assign bus.halted       = halted;
    assign bus.instr_count  = instr_count;
endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath with a combinational-read memory model.
module tb_cpu_datapath;
    localparam int AWIDTH = 5;
    localparam int DWIDTH = 8;
    localparam int CNT_W  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total  = 0;
    logic [DWIDTH-1:0] mem [0:(1<<AWIDTH)-1];

    cpu_datapath_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CNT_W(CNT_W)) bus ();

    cpu_datapath #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clr();
        bus.sel = 0; bus.rd = 0; bus.ld_ir = 0; bus.halt = 0; bus.inc_pc = 0;
        bus.ld_ac = 0; bus.ld_pc = 0; bus.wr = 0; bus.data_e = 0;
    endtask

    // Memory samples the write at the clock edge; values captured just before it.
    task automatic tick();
        logic              we;
        logic [AWIDTH-1:0] a;
        logic [DWIDTH-1:0] d;
        #1;
        we = bus.mem_we; a = bus.mem_addr; d = bus.mem_wdata;
        @(posedge clk);
        if (we) mem[a] = d;
        #1;
    endtask

    task automatic fetch(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] w);
        mem[a] = w;
        clr(); bus.sel = 1; bus.ld_ir = 1;
        tick(); clr();
    endtask

    task automatic load_acc(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] v);
        mem[a] = v;
        clr(); bus.ld_ac = 1;
        tick(); clr();
    endtask

    initial begin
        for (int i = 0; i < (1<<AWIDTH); i++) mem[i] = '0;
        clr();
        #12;
        chk("rst_pc", bus.pc, 0);
        chk("rst_acc", bus.acc, 0);
        chk("rst_opcode", bus.opcode, 0);
        chk("rst_is_zero", bus.is_zero, 1);
        chk("rst_halted", bus.halted, 0);
        chk("rst_count", bus.instr_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Build pc=12, acc=0x33, ir=0x45 then reset mid-cycle
        fetch(0, 8'hA5);
        load_acc(5, 8'h33);
        fetch(0, 8'hEC);
        bus.ld_pc = 1; tick(); clr();
        fetch(12, 8'h45);
        chk("pre_pc", bus.pc, 12);
        chk("pre_acc", bus.acc, 8'h33);
        chk("pre_opcode", bus.opcode, 3'b010);
        chk("pre_count", bus.instr_count, 3);
        bus.sel = 1;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_pc", bus.pc, 0);
        chk("mid_rst_acc", bus.acc, 0);
        chk("mid_rst_opcode", bus.opcode, 0);
        chk("mid_rst_is_zero", bus.is_zero, 1);
        chk("mid_rst_count", bus.instr_count, 0);
        chk("mid_rst_addr", bus.mem_addr, 0);
        #2 rst = 1'b0;
        clr();
        @(posedge clk); #1;

        // Fetch with ld_ir held two cycles
        fetch(0, 8'hE3);
        bus.ld_pc = 1; tick(); clr();
        chk("jmp3_pc", bus.pc, 3);
        mem[3] = 8'hA7;
        bus.sel = 1; bus.rd = 1; bus.ld_ir = 1;
        #1;
        chk("fetch_addr", bus.mem_addr, 3);
        chk("fetch_re", bus.mem_re, 1);
        tick(); tick();
        clr(); bus.inc_pc = 1; tick(); clr();
        chk("fetch_opcode", bus.opcode, 3'b101);
        chk("fetch_count", bus.instr_count, 2);
        chk("fetch_pc", bus.pc, 4);

        // ALU: ADD with carry out, AND to zero, XOR, non-ALU opcode holds acc
        load_acc(7, 8'hF0);
        fetch(4, 8'h45);
        mem[5] = 8'h20;
        bus.rd = 1; bus.ld_ac = 1;
        #1;
        chk("add_addr", bus.mem_addr, 5);
        tick(); clr();
        chk("add_acc", bus.acc, 8'h10);
        chk("add_is_zero", bus.is_zero, 0);
        fetch(4, 8'h65);
        load_acc(5, 8'h0F);
        chk("and_acc", bus.acc, 8'h00);
        chk("and_is_zero", bus.is_zero, 1);
        fetch(4, 8'h85);
        load_acc(5, 8'h3C);
        chk("xor_acc", bus.acc, 8'h3C);
        fetch(4, 8'h25);
        load_acc(5, 8'hFF);
        chk("skz_acc_hold", bus.acc, 8'h3C);
        chk("alu_count", bus.instr_count, 6);

        // JMP priority over inc_pc, then wrap
        fetch(4, 8'hFA);
        bus.ld_pc = 1; bus.inc_pc = 1;
        tick();
        chk("jmp_pc_1", bus.pc, 26);
        tick(); clr();
        chk("jmp_pc_2", bus.pc, 26);
        fetch(26, 8'hFF);
        bus.ld_pc = 1; tick(); clr();
        chk("jmp31_pc", bus.pc, 31);
        bus.inc_pc = 1; tick(); clr();
        chk("wrap_pc", bus.pc, 0);

        // STO
        fetch(0, 8'hA5);
        load_acc(5, 8'h5C);
        fetch(0, 8'hC9);
        bus.wr = 1; bus.data_e = 1;
        #1;
        chk("sto_addr", bus.mem_addr, 9);
        chk("sto_we", bus.mem_we, 1);
        chk("sto_wdata", bus.mem_wdata, 8'h5C);
        chk("sto_oe", bus.mem_wdata_oe, 1);
        tick(); clr();
        chk("sto_mem", mem[9], 8'h5C);
        chk("sto_count", bus.instr_count, 10);

        // Halt, with a load strobe in the same cycle, then ignored pulses
        bus.halt = 1; bus.inc_pc = 1; tick(); clr();
        chk("halt_flag", bus.halted, 1);
        chk("halt_same_pc", bus.pc, 0);
        mem[9] = 8'h00;
        bus.ld_ac = 1; tick(); clr();
        bus.inc_pc = 1; tick(); clr();
        bus.sel = 1; bus.ld_ir = 1; tick(); clr();
        bus.wr = 1; bus.rd = 1; bus.data_e = 1;
        #1;
        chk("halt_we", bus.mem_we, 0);
        chk("halt_re", bus.mem_re, 0);
        chk("halt_oe", bus.mem_wdata_oe, 0);
        tick(); clr();
        chk("halt_mem9", mem[9], 8'h00);
        chk("halt_pc", bus.pc, 0);
        chk("halt_acc", bus.acc, 8'h5C);
        chk("halt_opcode", bus.opcode, 3'b110);
        chk("halt_count", bus.instr_count, 10);
        #2 rst = 1'b1;
        #1;
        chk("halt_rst", bus.halted, 0);
        #2 rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cpu_datapath.md
# cpu_datapath

Accumulator datapath for the 8-bit, 8-opcode RISC core: program counter, instruction register, accumulator, ALU and memory address mux. It sits directly downstream of the core controller FSM. It consumes the controller's registered strobes (sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e) and drives the program/data memory port. It feeds opcode and is_zero back to the controller, and adds a halted flag and a retired-instruction counter for debug.

## Interface
- AWIDTH, 5, memory address width; instruction operand field width.
- DWIDTH, 8, data/instruction width; must equal AWIDTH+3 (opcode in bits [DWIDTH-1:DWIDTH-3]).
- CNT_W, 16, retired-instruction counter width.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- sel, rd, ld_ir, halt, inc_pc, ld_ac, ld_pc, wr, data_e  in  1 each  controller strobes, sampled at posedge clk.
- mem_rdata  in  DWIDTH  memory read data; combinational read, valid in the same cycle as mem_addr.
- mem_addr  out  AWIDTH  sel ? pc : ir[AWIDTH-1:0].
- mem_re  out  1  rd & ~halted.
- mem_we  out  1  wr & ~halted.
- mem_wdata  out  DWIDTH  acc.
- mem_wdata_oe  out  1  data_e & ~halted; write-bus drive enable.
- opcode  out  3  ir[DWIDTH-1:DWIDTH-3].
- is_zero  out  1  (acc == 0), combinational.
- pc  out  AWIDTH  program counter.
- acc  out  DWIDTH  accumulator.
- halted  out  1  sticky halt flag.
- instr_count  out  CNT_W  retired instructions, saturating.

## Operation
- Opcodes: 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP.
- IR: when ld_ir is 1, ir <= mem_rdata. Multi-cycle ld_ir reloads the same word, which is harmless.
- PC:
  - When ld_pc is 1, pc <= ir[AWIDTH-1:0].
  - Else when inc_pc is 1, pc <= pc+1, wrapping 2^AWIDTH-1 -> 0.
  - ld_pc has priority when both are high.
- ACC: when ld_ac is 1, acc <= alu_out. alu_out is selected by opcode:
  - ADD: acc + mem_rdata, modulo 2^DWIDTH, carry discarded.
  - AND: acc & mem_rdata.
  - XOR: acc ^ mem_rdata.
  - LDA: mem_rdata.
  - All other opcodes: acc, unchanged.
- SKZ, STO and JMP need no special decode here. Their effects arrive via inc_pc, wr/data_e and ld_pc from the controller.
- Halt:
  - A sampled halt=1 sets halted; only rst clears it.
  - While halted is 1 (including the cycle it is set), pc, ir and acc are frozen and all load strobes are ignored.
  - mem_we, mem_re and mem_wdata_oe are forced to 0 while halted.
- instr_count:
  - Increments by 1 on each rising edge of ld_ir (ld_ir=1, previous ld_ir=0), unless halted.
  - Saturates at 2^CNT_W-1.
  - A one-bit ld_ir history register implements the edge detect.

## Timing
- Reset is asynchronous. Immediately on rst=1: pc=0, ir=0, acc=0, halted=0, instr_count=0, ld_ir history=0.
  - Consequently opcode=000, is_zero=1, mem_addr follows sel (0 either way), mem_wdata=0.
  - mem_we, mem_re and mem_wdata_oe equal the current strobes, which the controller also holds at 0 in reset.
- Reset mid-instruction discards all in-flight state. There is no partial write beyond the current cycle.
- The strobes are registered controller outputs. This block's register updates take effect at the posedge ending the cycle in which the strobe is high, i.e. 1-cycle latency from strobe to new pc/ir/acc.
- mem_addr, mem_re, mem_we, mem_wdata, mem_wdata_oe, opcode and is_zero are combinational from current registers and strobes, with no added latency.
- The ACC update uses mem_rdata at the same posedge. Memory must present read data combinationally within the cycle.
- A STO write lands at the posedge ending the cycle with wr=1. The memory samples mem_wdata=acc at that edge.
- Per instruction, the controller produces 8 cycles. The datapath has no stall and no back-pressure.

## Test plan
- Reset mid-run with pc=12, acc=0x33, ir=0x45 -> same-cycle pc=0, acc=0, ir=0, opcode=000, is_zero=1, instr_count=0.
- Fetch: pc=3, mem[3]=0xA7, then sel=1, rd=1, ld_ir high 2 cycles, then inc_pc 1 cycle -> mem_addr=3, ir=0xA7, opcode=101, instr_count +1 (once), pc=4.
- ALU: acc=0xF0, ir=0x45 (ADD 5), mem[5]=0x20, sel=0, rd=1, ld_ac=1 -> mem_addr=5, acc=0x10, is_zero=0. Then AND with mem=0x0F -> acc=0x00, is_zero=1.
- JMP and wrap:
  - ir=0xFA (JMP 26) with ld_pc and inc_pc both high for 2 cycles -> pc=26 after each edge.
  - pc=31 with inc_pc -> pc=0.
- STO: acc=0x5C, ir=0xC9 (STO 9), sel=0, wr=1, data_e=1 -> mem_addr=9, mem_we=1, mem_wdata=0x5C, mem_wdata_oe=1. The memory model holds mem[9]=0x5C.
- Halt: halt=1 for one cycle, then pulses of ld_ac, inc_pc, ld_ir and wr -> halted=1, pc/acc/ir/instr_count unchanged, mem_we=0. After rst -> halted=0.
